// File: rtl/game_pkg.sv
// Shared definitions for the game referee: action and winner codes, health
// width and referee state encodings.
package game_pkg;

    localparam logic [2:0] ACT_KICK   = 3'b000;
    localparam logic [2:0] ACT_PUNCH  = 3'b001;
    localparam logic [2:0] AWAIT_ACT  = 3'b010;
    localparam logic [2:0] ACT_BLOCK  = 3'b011;
    localparam logic [2:0] ACT_LEFT1  = 3'b100;
    localparam logic [2:0] ACT_LEFT2  = 3'b101;
    localparam logic [2:0] ACT_RIGHT1 = 3'b110;
    localparam logic [2:0] ACT_RIGHT2 = 3'b111;

    localparam int                  HEALTH_W   = 2;
    localparam logic [HEALTH_W-1:0] HEALTH_MAX = 2'b11;

    localparam int TIMER_W = 27;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_OVER    = 3'd5
    } ref_state_t;

    // Decides a round that ran out of turns with both players still standing.
    function automatic winner_t points_winner(input logic [HEALTH_W-1:0] h1,
                                              input logic [HEALTH_W-1:0] h2);
        if (h1 > h2)
            return WIN_P1;
        else if (h2 > h1)
            return WIN_P2;
        else
            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/game_referee_turn_timer.sv
// Per-turn deadline: down-counter reloaded by clear, expire high on the last
// tick of the turn.
module turn_timer
    import game_pkg::*;
#(
    parameter int TURN_TICKS = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TURN_TICKS - 1);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= RELOAD;
        else if (clear)
            count <= RELOAD;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expire = (count == '0);

endmodule

// File: rtl/game_referee.sv
// Turn controller for two players: collects actions, commits them with a
// one-cycle strobe, then judges health to continue or end the round.
module game_referee
    import game_pkg::*;
#(
    parameter int TURN_TICKS = 50_000_000,
    parameter int MAX_TURNS  = 99
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                p1_ready,
    input  logic                p2_ready,
    input  logic [2:0]          p1_sw,
    input  logic [2:0]          p2_sw,
    input  logic [HEALTH_W-1:0] health1,
    input  logic [HEALTH_W-1:0] health2,
    output logic [2:0]          action1,
    output logic [2:0]          action2,
    output logic                actionEnable,
    output logic                round_reset,
    output logic                isGameOver,
    output logic [1:0]          winner,
    output logic [7:0]          turn_count
);

    localparam logic [8:0] MAX_TURNS_W = 9'(MAX_TURNS);

    ref_state_t state;
    logic       p1_latched, p2_latched;
    logic [2:0] p1_act, p2_act;
    logic       timer_clear, timer_expire;

    logic       p1_take, p2_take, both_done;
    logic [2:0] p1_act_nxt, p2_act_nxt;
    logic [7:0] turn_inc;
    logic       settle_over;
    winner_t    settle_winner;

    assign timer_clear = (state != ST_COLLECT);

    turn_timer #(.TURN_TICKS(TURN_TICKS)) u_turn_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .expire (timer_expire)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        p1_take       = (state == ST_COLLECT) && p1_ready && !p1_latched;
        p2_take       = (state == ST_COLLECT) && p2_ready && !p2_latched;
        p1_act_nxt    = p1_take ? p1_sw : p1_act;
        p2_act_nxt    = p2_take ? p2_sw : p2_act;
        both_done     = (p1_latched || p1_take) && (p2_latched || p2_take);
        turn_inc      = (turn_count == 8'hFF) ? turn_count : turn_count + 8'd1;
        settle_over   = 1'b1;
        settle_winner = WIN_NONE;
        if (health1 == '0 && health2 == '0)
            settle_winner = WIN_DRAW;
        else if (health1 == '0)
            settle_winner = WIN_P2;
        else if (health2 == '0)
            settle_winner = WIN_P1;
        else if ({1'b0, turn_count} + 9'd1 == MAX_TURNS_W)
            settle_winner = points_winner(health1, health2);
        else
            settle_over = 1'b0;
    end

    // Outputs are set on the transition into the state they belong to, so they
    // are registered yet line up exactly with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            action1      <= AWAIT_ACT;
            action2      <= AWAIT_ACT;
            actionEnable <= 1'b0;
            round_reset  <= 1'b0;
            isGameOver   <= 1'b0;
            winner       <= WIN_NONE;
            turn_count   <= 8'd0;
            p1_latched   <= 1'b0;
            p2_latched   <= 1'b0;
            p1_act       <= AWAIT_ACT;
            p2_act       <= AWAIT_ACT;
        end else begin
            actionEnable <= 1'b0;
            round_reset  <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state       <= ST_CLEAR;
                        round_reset <= 1'b1;
                        turn_count  <= 8'd0;
                        winner      <= WIN_NONE;
                        isGameOver  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state      <= ST_COLLECT;
                    p1_latched <= 1'b0;
                    p2_latched <= 1'b0;
                    p1_act     <= AWAIT_ACT;
                    p2_act     <= AWAIT_ACT;
                end
                ST_COLLECT: begin
                    p1_latched <= p1_latched || p1_take;
                    p2_latched <= p2_latched || p2_take;
                    p1_act     <= p1_act_nxt;
                    p2_act     <= p2_act_nxt;
                    // A confirmation arriving on the timeout cycle still counts.
                    if (both_done || timer_expire) begin
                        state        <= ST_COMMIT;
                        action1      <= p1_act_nxt;
                        action2      <= p2_act_nxt;
                        actionEnable <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    turn_count <= turn_inc;
                    p1_latched <= 1'b0;
                    p2_latched <= 1'b0;
                    p1_act     <= AWAIT_ACT;
                    p2_act     <= AWAIT_ACT;
                    if (settle_over) begin
                        state      <= ST_OVER;
                        isGameOver <= 1'b1;
                        winner     <= settle_winner;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee: stimulus queues expected CLEAR/COMMIT/OVER
// events, a negedge monitor pops and compares them as the DUT raises them.
module tb_game_referee;

    localparam int TURN_TICKS = 8;
    localparam int MAX_TURNS  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       p1_ready = 1'b0;
    logic       p2_ready = 1'b0;
    logic [2:0] p1_sw = 3'b000;
    logic [2:0] p2_sw = 3'b000;
    logic [1:0] health1 = 2'b11;
    logic [1:0] health2 = 2'b11;
    logic [2:0] action1, action2;
    logic       actionEnable, round_reset, isGameOver;
    logic [1:0] winner;
    logic [7:0] turn_count;

    game_referee #(
        .TURN_TICKS (TURN_TICKS),
        .MAX_TURNS  (MAX_TURNS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .p1_ready     (p1_ready),
        .p2_ready     (p2_ready),
        .p1_sw        (p1_sw),
        .p2_sw        (p2_sw),
        .health1      (health1),
        .health2      (health2),
        .action1      (action1),
        .action2      (action2),
        .actionEnable (actionEnable),
        .round_reset  (round_reset),
        .isGameOver   (isGameOver),
        .winner       (winner),
        .turn_count   (turn_count)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_CLEAR, EV_COMMIT, EV_OVER} ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [1:0] w;
        logic [7:0] tc;
    } exp_t;

    // One directed turn: cycle index (within COLLECT) of each ready pulse,
    // -1 for none, and the hand-computed outcome.
    typedef struct {
        int         c1;
        logic [2:0] s1;
        int         c1b;
        logic [2:0] s1b;
        int         c2;
        logic [2:0] s2;
        logic [1:0] h1;
        logic [1:0] h2;
        int         commit_at;
        logic [2:0] e1;
        logic [2:0] e2;
        bit         ends;
        logic [1:0] ew;
        logic [7:0] et;
    } turn_t;

    exp_t       sb[$];
    turn_t      tv[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] last_a1 = 3'b010;
    logic [2:0] last_a2 = 3'b010;
    bit         prev_over = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input ev_kind_t k, input logic [2:0] a1, input logic [2:0] a2,
                                    input logic [1:0] w, input logic [7:0] tc);
        exp_t e;
        e.kind = k;
        e.a1   = a1;
        e.a2   = a2;
        e.w    = w;
        e.tc   = tc;
        return e;
    endfunction

    task automatic pop_and_check(input ev_kind_t k, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_%s: event seen, expected none (t=%0t)", tag, $time);
            return;
        end
        e = sb.pop_front();
        check({tag, "_kind"}, 32'(k), 32'(e.kind));
        case (k)
            EV_CLEAR: begin
                check("clear_action1", action1, e.a1);
                check("clear_action2", action2, e.a2);
                check("clear_over", isGameOver, 1'b0);
                check("clear_winner", winner, 2'b00);
                check("clear_turns", turn_count, 8'd0);
            end
            EV_COMMIT: begin
                check("commit_action1", action1, e.a1);
                check("commit_action2", action2, e.a2);
            end
            default: begin
                check("over_winner", winner, e.w);
                check("over_turns", turn_count, e.tc);
            end
        endcase
    endtask

    // Monitor: reacts to whatever the DUT presents, independent of stimulus.
    always @(negedge clk) begin
        if (reset) begin
            if (actionEnable || round_reset)
                check("strobe_overlap", actionEnable & round_reset, 1'b0);
            if (round_reset)
                pop_and_check(EV_CLEAR, "clear");
            if (actionEnable)
                pop_and_check(EV_COMMIT, "commit");
            if (isGameOver && !prev_over)
                pop_and_check(EV_OVER, "over");
        end
        prev_over = isGameOver;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one ns into the first COLLECT cycle.
    task automatic start_round();
        sb.push_back(mk_exp(EV_CLEAR, last_a1, last_a2, 2'b00, 8'd0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic play_turn(input turn_t t);
        health1 = t.h1;
        health2 = t.h2;
        sb.push_back(mk_exp(EV_COMMIT, t.e1, t.e2, 2'b00, 8'd0));
        if (t.ends)
            sb.push_back(mk_exp(EV_OVER, 3'b000, 3'b000, t.ew, t.et));
        for (int k = 0; k < t.commit_at; k++) begin
            p1_ready = (k == t.c1) || (k == t.c1b);
            p1_sw    = (k == t.c1b) ? t.s1b : ((k == t.c1) ? t.s1 : ~t.s1);
            p2_ready = (k == t.c2);
            p2_sw    = (k == t.c2) ? t.s2 : ~t.s2;
            tick();
        end
        p1_ready = 1'b0;
        p2_ready = 1'b0;
        @(negedge clk);
        check("commit_timing", actionEnable, 1'b1);
        last_a1 = t.e1;
        last_a2 = t.e2;
        tick();
        tick();
    endtask

    task automatic poke_over(input logic [1:0] ew, input logic [7:0] et);
        for (int k = 0; k < 3; k++) begin
            p1_ready = 1'b1;
            p2_ready = 1'b1;
            p1_sw    = 3'b101;
            p2_sw    = 3'b011;
            tick();
            p1_ready = 1'b0;
            p2_ready = 1'b0;
            tick();
        end
        check("over_held", isGameOver, 1'b1);
        check("winner_held", winner, ew);
        check("turns_held", turn_count, et);
        check("actions_held1", action1, last_a1);
        check("actions_held2", action2, last_a2);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int round_len[5] = '{3, 1, 1, 1, 3};
        int idx = 0;

        //           c1  s1     c1b s1b     c2  s2     h1     h2     at e1     e2     end ew     et
        tv.push_back('{0, 3'b000, -1, 3'b000, 1, 3'b001, 2'b11, 2'b11, 2, 3'b000, 3'b001, 1'b0, 2'b00, 8'd0});
        tv.push_back('{0, 3'b100, -1, 3'b000, -1, 3'b000, 2'b11, 2'b11, 8, 3'b100, 3'b010, 1'b0, 2'b00, 8'd0});
        tv.push_back('{0, 3'b000, 1, 3'b111, 2, 3'b011, 2'b11, 2'b11, 3, 3'b000, 3'b011, 1'b1, 2'b11, 8'd3});
        tv.push_back('{0, 3'b101, -1, 3'b000, 0, 3'b110, 2'b11, 2'b00, 1, 3'b101, 3'b110, 1'b1, 2'b01, 8'd1});
        tv.push_back('{-1, 3'b000, -1, 3'b000, -1, 3'b000, 2'b00, 2'b10, 8, 3'b010, 3'b010, 1'b1, 2'b10, 8'd1});
        tv.push_back('{3, 3'b001, -1, 3'b000, 7, 3'b111, 2'b00, 2'b00, 8, 3'b001, 3'b111, 1'b1, 2'b11, 8'd1});
        tv.push_back('{0, 3'b011, -1, 3'b000, 0, 3'b100, 2'b01, 2'b10, 1, 3'b011, 3'b100, 1'b0, 2'b00, 8'd0});
        tv.push_back('{-1, 3'b000, -1, 3'b000, 2, 3'b101, 2'b01, 2'b10, 8, 3'b010, 3'b101, 1'b0, 2'b00, 8'd0});
        tv.push_back('{5, 3'b110, -1, 3'b000, 6, 3'b000, 2'b01, 2'b10, 7, 3'b110, 3'b000, 1'b1, 2'b10, 8'd3});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_action1", action1, 3'b010);
        check("rst_action2", action2, 3'b010);
        check("rst_enable", actionEnable, 1'b0);
        check("rst_round_reset", round_reset, 1'b0);
        check("rst_over", isGameOver, 1'b0);
        check("rst_winner", winner, 2'b00);
        check("rst_turns", turn_count, 8'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        for (int r = 0; r < 5; r++) begin
            start_round();
            for (int j = 0; j < round_len[r]; j++) begin
                play_turn(tv[idx]);
                idx++;
            end
            poke_over(tv[idx - 1].ew, tv[idx - 1].et);
        end

        // Reset in the middle of COLLECT discards the latched action.
        start_round();
        p1_ready = 1'b1;
        p1_sw    = 3'b011;
        tick();
        p1_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_action1", action1, 3'b010);
        check("midrst_action2", action2, 3'b010);
        check("midrst_enable", actionEnable, 1'b0);
        check("midrst_over", isGameOver, 1'b0);
        check("midrst_winner", winner, 2'b00);
        check("midrst_turns", turn_count, 8'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        last_a1 = 3'b010;
        last_a2 = 3'b010;
        for (int k = 0; k < 3; k++) begin
            p1_ready = 1'b1;
            p2_ready = 1'b1;
            tick();
            p1_ready = 1'b0;
            p2_ready = 1'b0;
            tick();
        end
        repeat (TURN_TICKS + 2) tick();
        check("idle_action1", action1, 3'b010);
        check("idle_action2", action2, 3'b010);
        check("idle_over", isGameOver, 1'b0);

        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
